// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the fetch PC, drives a single-outstanding req/ack
// instruction-memory port and holds the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall_f,
  input  logic        flush_d,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] fetch_addr, fetch_nx;
  logic [31:0] buf_inst, buf_nx;
  logic        id_load;
  logic [31:0] id_load_inst;
  logic        id_bubble;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = fetch_addr;
  assign imem_req  = !rst && ((state == S_REQ) || (state == S_DROP));

  // id_bubble marks cycles where the slot empties unless stall_f holds it;
  // id_load only fires with stall_f low, so it always takes precedence.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    fetch_nx     = fetch_addr;
    buf_nx       = buf_inst;
    id_load      = 1'b0;
    id_load_inst = buf_inst;
    id_bubble    = !stall_f;
    unique case (state)
      S_REQ: begin
        if (redirect && imem_ack) begin
          pc_nx    = npc;
          fetch_nx = npc;
        end else if (redirect) begin
          pc_nx    = npc;
          state_nx = S_DROP;
        end else if (imem_ack && !stall_f) begin
          id_load      = 1'b1;
          id_load_inst = imem_rdata;
          pc_nx        = npc;
          fetch_nx     = npc;
        end else if (imem_ack) begin
          buf_nx   = imem_rdata;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nx    = npc;
          fetch_nx = npc;
          state_nx = S_REQ;
        end else if (!stall_f) begin
          id_load      = 1'b1;
          id_load_inst = buf_inst;
          pc_nx        = npc;
          fetch_nx     = npc;
          state_nx     = S_REQ;
        end
      end
      S_DROP: begin
        // The stale response only retires the old request; the newest target
        // (pc, or npc if redirected in the same cycle) becomes the fetch address.
        if (redirect) begin
          pc_nx = npc;
          if (imem_ack) begin
            fetch_nx = npc;
            state_nx = S_REQ;
          end
        end else if (imem_ack) begin
          fetch_nx = pc;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      buf_inst   <= NOP_INST;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      fetch_addr <= fetch_nx;
      buf_inst   <= buf_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
      id_pc    <= '0;
    end else if (flush_d) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (id_load) begin
      id_valid <= 1'b1;
      id_inst  <= id_load_inst;
      id_pc    <= fetch_addr;
    end else if (id_bubble) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory returns a fixed function of the address,
// npc follows pc_plus4 unless a redirect target is driven.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        redirect;
  logic        stall_f;
  logic        flush_d;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] tgt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .npc       (npc),
    .redirect  (redirect),
    .stall_f   (stall_f),
    .flush_d   (flush_d),
    .pc_plus4  (pc_plus4),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_inst   (id_inst),
    .id_pc     (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_rdata = inst_of(imem_addr);
  assign npc        = redirect ? tgt : pc_plus4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall_f = 1'b0; flush_d = 1'b0; tgt = '0;
    step();
    step();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_inst",  id_inst, NOP);
    check("rst_idpc",  id_pc, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_pc4",   pc_plus4, 32'd4);

    // T1: ack every cycle, sequential fetch
    rst = 1'b0; imem_ack = 1'b1;
    step();
    check("t1_valid0", {31'd0, id_valid}, 32'd1);
    check("t1_pc0",    id_pc, 32'h0);
    check("t1_inst0",  id_inst, inst_of(32'h0));
    check("t1_addr0",  imem_addr, 32'h4);
    step();
    check("t1_pc1",    id_pc, 32'h4);
    check("t1_addr1",  imem_addr, 32'h8);
    step();
    check("t1_pc2",    id_pc, 32'h8);
    step();
    check("t1_pc3",    id_pc, 32'hC);
    check("t1_inst3",  id_inst, inst_of(32'hC));
    check("t1_addr3",  imem_addr, 32'h10);

    // T2: ack delayed three cycles at 0x10
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait_valid", {31'd0, id_valid}, 32'd0);
      check("t2_wait_addr",  imem_addr, 32'h10);
      check("t2_wait_req",   {31'd0, imem_req}, 32'd1);
    end
    check("t2_wait_inst", id_inst, NOP);
    imem_ack = 1'b1;
    step();
    check("t2_valid", {31'd0, id_valid}, 32'd1);
    check("t2_idpc",  id_pc, 32'h10);
    check("t2_inst",  id_inst, inst_of(32'h10));
    check("t2_addr",  imem_addr, 32'h14);

    // T3: redirect to 0x100 while 0x14 is pending
    imem_ack = 1'b0; redirect = 1'b1; tgt = 32'h100;
    step();
    redirect = 1'b0;
    check("t3_stale_addr", imem_addr, 32'h14);
    check("t3_valid0",     {31'd0, id_valid}, 32'd0);
    check("t3_pc4",        pc_plus4, 32'h104);
    step();
    check("t3_drop_req",   {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    step();
    check("t3_discard",    {31'd0, id_valid}, 32'd0);
    check("t3_new_addr",   imem_addr, 32'h100);
    step();
    check("t3_idpc",       id_pc, 32'h100);
    check("t3_inst",       id_inst, inst_of(32'h100));
    check("t3_valid1",     {31'd0, id_valid}, 32'd1);

    // T4: redirect+ack to 0x1C, load 0x1C, then stall over the ack at 0x20
    redirect = 1'b1; tgt = 32'h1C;
    step();
    redirect = 1'b0;
    check("t4_redir_addr",  imem_addr, 32'h1C);
    check("t4_redir_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("t4_live_pc", id_pc, 32'h1C);
    stall_f = 1'b1;
    step();
    imem_ack = 1'b0;
    check("t4_hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_frozen_pc",    id_pc, 32'h1C);
      check("t4_frozen_valid", {31'd0, id_valid}, 32'd1);
      check("t4_frozen_req",   {31'd0, imem_req}, 32'd0);
    end
    stall_f = 1'b0;
    step();
    check("t4_rel_pc",   id_pc, 32'h20);
    check("t4_rel_inst", id_inst, inst_of(32'h20));
    check("t4_rel_addr", imem_addr, 32'h24);
    check("t4_rel_req",  {31'd0, imem_req}, 32'd1);

    // T5: flush beats stall hold, then flush beats a load
    stall_f = 1'b1; flush_d = 1'b1;
    step();
    check("t5_valid", {31'd0, id_valid}, 32'd0);
    check("t5_inst",  id_inst, NOP);
    stall_f = 1'b0; imem_ack = 1'b1;
    step();
    check("t5_load_valid", {31'd0, id_valid}, 32'd0);
    check("t5_load_inst",  id_inst, NOP);
    check("t5_addr",       imem_addr, 32'h28);
    flush_d = 1'b0; imem_ack = 1'b0;

    // T6: reset while in DROP
    redirect = 1'b1; tgt = 32'h200;
    step();
    redirect = 1'b0;
    check("t6_drop_addr", imem_addr, 32'h28);
    rst = 1'b1;
    step();
    check("t6_rst_req",   {31'd0, imem_req}, 32'd0);
    check("t6_rst_addr",  imem_addr, 32'h0);
    check("t6_rst_valid", {31'd0, id_valid}, 32'd0);
    rst = 1'b0;
    step();
    check("t6_req",  {31'd0, imem_req}, 32'd1);
    check("t6_addr", imem_addr, 32'h0);

    // pc_plus4 wrap at the top of the address space
    imem_ack = 1'b1; redirect = 1'b1; tgt = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc4",  pc_plus4, 32'h0);
    step();
    check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    check("wrap_next", imem_addr, 32'h0);
    imem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
